// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared 5-bit Galois LFSR definitions for generator and checker
package lfsr_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } lfsr_state_e;

  // Galois step: shift right, feedback from bit 0 into bits 4 and 2
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[0], s[4], s[3] ^ s[0], s[2], s[1]};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - sample input and status output bundle of the LFSR checker
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);

  logic                          in_valid;
  logic [lfsr_pkg::LFSR_W-1:0]   in_state;
  logic                          clr_count;
  logic                          locked;
  logic                          err_pulse;
  logic [CNT_W-1:0]              err_count;

  modport master (
    output in_valid, in_state, clr_count,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_state, clr_count,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - HUNT/LOCKED checker for a received 5-bit Galois LFSR stream
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSE_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  lfsr_checker_if.slave   bus
);

  localparam int MATCH_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = (LOSE_CNT < 1) ? 1 : $clog2(LOSE_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  LOSE_LAST = MISS_W'(LOSE_CNT - 1);

  lfsr_state_e         r_state;
  logic [LFSR_W-1:0]   r_pred;
  logic                r_pred_ok;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [MISS_W-1:0]   r_miss_cnt;
  logic                r_err_pulse;
  logic [CNT_W-1:0]    r_err_count;

  logic                w_match;
  logic                w_err_inc;
  logic [LFSR_W-1:0]   w_next_in;
  logic [LFSR_W-1:0]   w_next_pred;

  assign w_match     = (bus.in_state == r_pred);
  assign w_next_in   = lfsr_next(bus.in_state);
  assign w_next_pred = lfsr_next(r_pred);
  assign w_err_inc   = bus.in_valid && (r_state == ST_LOCKED) && !w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_pred      <= LFSR_SEED;
      r_pred_ok   <= 1'b0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (bus.in_valid) begin
        if (r_state == ST_HUNT) begin
          // all-zero is outside the sequence and must not seed the predictor
          if (bus.in_state == '0) begin
            r_pred_ok   <= 1'b0;
            r_match_cnt <= '0;
          end else begin
            r_pred    <= w_next_in;
            r_pred_ok <= 1'b1;
            if (r_pred_ok && w_match) begin
              if (r_match_cnt == LOCK_LAST) begin
                r_state    <= ST_LOCKED;
                r_miss_cnt <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
        end else begin
          r_pred <= w_next_pred;
          if (w_match) begin
            r_miss_cnt <= '0;
          end else begin
            r_err_pulse <= 1'b1;
            if (r_miss_cnt == LOSE_LAST) begin
              r_state     <= ST_HUNT;
              r_pred_ok   <= 1'b0;
              r_match_cnt <= '0;
              r_miss_cnt  <= '0;
            end else begin
              r_miss_cnt <= r_miss_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  // clear beats a coincident increment; counter holds at all-ones
  always_ff @(posedge clk) begin
    if (rst || bus.clr_count) begin
      r_err_count <= '0;
    end else if (w_err_inc && !(&r_err_count)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign bus.locked    = (r_state == ST_LOCKED);
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_count;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4: consecutive predicted matches required to acquire lock.
REQ-002 The block SHALL have parameter LOSE_CNT, default 3: consecutive mismatches while locked that drop lock.
REQ-003 The block SHALL have parameter CNT_W, default 16: error counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_state carries a sample this cycle.
REQ-007 The block SHALL have port in_state, input, 5 bits: received 5-bit Galois LFSR state word.
REQ-008 The block SHALL have port clr_count, input, 1 bit: synchronous clear of err_count.
REQ-009 The block SHALL have port locked, output, 1 bit: checker is in LOCKED state.
REQ-010 The block SHALL have port err_pulse, output, 1 bit: one-cycle strobe per mismatching sample while locked.
REQ-011 The block SHALL have port err_count, output, CNT_W bits: saturating count of mismatches while locked.

Function
REQ-012 The next-state function SHALL be: n[4]=s[0], n[3]=s[4], n[2]=s[3]^s[0], n[1]=s[2], n[0]=s[1] (period 31, nonzero states).
REQ-013 The FSM SHALL have two states, HUNT and LOCKED, with registers pred[4:0], pred_ok, match_cnt and miss_cnt.
REQ-014 Cycles with in_valid=0 SHALL change no state, counter, or predictor; err_pulse SHALL be 0 on the following cycle.
REQ-015 In HUNT with valid sample: if pred_ok and in_state==pred, match_cnt SHALL increment; otherwise match_cnt SHALL be cleared to 0.
REQ-016 In HUNT, every valid sample SHALL reseed: pred <= next(in_state), pred_ok <= 1; a sample of 5'b00000 SHALL instead set pred_ok <= 0 and match_cnt <= 0.
REQ-017 In HUNT, the matching sample that brings match_cnt to LOCK_CNT SHALL move the FSM to LOCKED with miss_cnt=0; with defaults, lock occurs on the edge consuming the 5th consecutive valid sequence sample.
REQ-018 In LOCKED with valid sample, pred SHALL advance to next(pred) (flywheel) regardless of match; the input SHALL never reseed the predictor.
REQ-019 In LOCKED, a match SHALL clear miss_cnt.
REQ-020 In LOCKED, a mismatch SHALL set err_pulse=1 for exactly the next cycle, increment err_count (saturating at all-ones), and increment miss_cnt.
REQ-021 The mismatch that brings miss_cnt to LOSE_CNT SHALL return the FSM to HUNT with pred_ok=0 and match_cnt=0; that mismatch SHALL still be counted and pulsed.
REQ-022 Mismatches in HUNT SHALL never pulse err_pulse or change err_count.
REQ-023 When clr_count and an increment coincide, clear SHALL win and err_count SHALL be 0.
REQ-024 clr_count SHALL NOT affect FSM state or lock.
REQ-025 locked and err_pulse SHALL be registered outputs; locked SHALL reflect the FSM state with no added latency beyond the state register.

Reset
REQ-026 On rst=1 at a clock edge: state=HUNT, pred=5'b00001, pred_ok=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0.
REQ-027 Reset mid-lock SHALL discard lock; reacquisition SHALL require the full LOCK_CNT+1 sample sequence.
REQ-028 rst SHALL take precedence over clr_count and in_valid.

Structure
REQ-029 Package lfsr_pkg SHALL hold LFSR_W=5, LFSR_SEED=5'b00001, the FSM state enum type, and the next-state function, shared with the generator.
REQ-030 No sub-module SHALL be created; the next-state logic SHALL be the package function, and the FSM, predictor and counters SHALL be in one module.

Verification
REQ-031 A bench SHALL cover: after reset, continuous valid sequence 01,14,0A,05,16,... -> locked=1 on the edge consuming 16 (5th sample), err_count=0.
REQ-032 A bench SHALL cover: once locked, replace one sample with 1F -> one err_pulse, err_count=1, locked stays 1, next correct sample matches (flywheel).
REQ-033 A bench SHALL cover: once locked, 3 consecutive corrupt samples -> 3 pulses, err_count=3, locked=0 after third; correct stream relocks after 5 samples.
REQ-034 A bench SHALL cover: in HUNT, feed 00 then valid sequence -> 00 does not seed; lock after 5 nonzero sequence samples; err_count unchanged.
REQ-035 A bench SHALL cover: in_valid gaps of 1-3 cycles inside the sequence -> lock timing counted in samples only, no errors.
REQ-036 A bench SHALL cover: CNT_W=2, force 5 spaced errors -> err_count saturates at 3; clr_count coincident with an error -> err_count=0.
